mux2_arbiter: RTL and testbench

Two-requester round-robin arbiter that owns the select line of a shared 2:1 word mux (the `mux_5` datapath element) and registers the selected word into a single-entry output buffer with a valid/ready handshake. It sits in front of a shared single-port resource, such as a register-file write port or a memory request port, that two pipeline sources contend for. Both sources are shared fairly and the consumer sees one clean, registered stream.

---
 rtl/mux2_arbiter.sv | 80 ++++++++
 tb/tb_mux2_arbiter.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/mux2_arbiter.sv
// Two-requester arbiter driving the select of a shared 2:1 word mux, feeding a
// single-entry registered output buffer. Define MUX2_ARB_FIXED_PRIO_EN for fixed A-first priority.
module mux2_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_req,
  input  logic [WIDTH-1:0] a_data,
  output logic             a_gnt,
  input  logic             b_req,
  input  logic [WIDTH-1:0] b_data,
  output logic             b_gnt,
  output logic             mux_sel,
  output logic             y_valid,
  output logic [WIDTH-1:0] y_data,
  output logic             y_src,
  input  logic             y_ready
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} buf_state_t;

  buf_state_t       state, state_next;
  logic             last;
  logic             winner;
  logic             acc;
  logic             gnt;
  logic [WIDTH-1:0] mux_out;

  assign y_valid = (state == FULL);
  assign acc     = (state == EMPTY) || y_ready;

  always_comb begin
    winner = last;
    if (a_req && !b_req)
      winner = 1'b0;
    else if (b_req && !a_req)
      winner = 1'b1;
    else if (a_req && b_req) begin
`ifdef MUX2_ARB_FIXED_PRIO_EN
      winner = 1'b0;
`else
      winner = ~last;
`endif
    end
  end

  assign mux_sel = winner;
  assign mux_out = mux_sel ? b_data : a_data;

  // Grants are masked during reset so nothing is offered while state is being cleared.
  assign a_gnt = !rst && acc && a_req && (winner == 1'b0);
  assign b_gnt = !rst && acc && b_req && (winner == 1'b1);
  assign gnt   = a_gnt || b_gnt;

  always_comb begin
    state_next = state;
    if (gnt)
      state_next = FULL;
    else if (state == FULL && y_ready)
      state_next = EMPTY;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= EMPTY;
      last   <= 1'b1;
      y_data <= '0;
      y_src  <= 1'b0;
    end else begin
      state <= state_next;
      if (gnt) begin
        y_data <= mux_out;
        y_src  <= winner;
        last   <= winner;
      end
    end
  end

endmodule

// File: tb/tb_mux2_arbiter.sv
// Directed self-checking bench for mux2_arbiter.
module tb_mux2_arbiter;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             a_req, b_req, y_ready;
  logic [WIDTH-1:0] a_data, b_data;
  logic             a_gnt, b_gnt, mux_sel, y_valid, y_src;
  logic [WIDTH-1:0] y_data;

  int checks = 0;
  int errors = 0;

  mux2_arbiter #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .a_req   (a_req),
    .a_data  (a_data),
    .a_gnt   (a_gnt),
    .b_req   (b_req),
    .b_data  (b_data),
    .b_gnt   (b_gnt),
    .mux_sel (mux_sel),
    .y_valid (y_valid),
    .y_data  (y_data),
    .y_src   (y_src),
    .y_ready (y_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [3:0]       rr_src;
  logic [WIDTH-1:0] exp_d;
  logic             exp_s;
  logic [WIDTH-1:0] hold;

  initial begin
`ifdef MUX2_ARB_FIXED_PRIO_EN
    rr_src = 4'b0000;
`else
    rr_src = 4'b1010;  // bit i = expected source of transfer i
`endif
    rst = 1'b1; a_req = 1'b0; b_req = 1'b0; y_ready = 1'b0;
    a_data = '0; b_data = '0;
    #2;
    chk("rst_valid", {31'b0, y_valid}, 32'd0);
    chk("rst_data",  y_data,           32'd0);
    chk("rst_src",   {31'b0, y_src},   32'd0);
    chk("rst_gnt",   {30'b0, a_gnt, b_gnt}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // single A transfer
    a_req = 1'b1; a_data = 32'h0A; y_ready = 1'b1;
    #1;
    chk("t1_a_gnt", {31'b0, a_gnt}, 32'd1);
    chk("t1_b_gnt", {31'b0, b_gnt}, 32'd0);
    chk("t1_sel",   {31'b0, mux_sel}, 32'd0);
    tick();
    a_req = 1'b0;
    chk("t1_valid", {31'b0, y_valid}, 32'd1);
    chk("t1_data",  y_data,           32'h0A);
    chk("t1_src",   {31'b0, y_src},   32'd0);

    // fresh reset, then both requesting for 4 cycles
    rst = 1'b1; #2 rst = 1'b0;
    a_req = 1'b1; a_data = 32'h0A; b_req = 1'b1; b_data = 32'h15; y_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_s = rr_src[i];
      exp_d = exp_s ? 32'h15 : 32'h0A;
      #1;
      chk("rr_sel",   {31'b0, mux_sel}, {31'b0, exp_s});
      chk("rr_gnt",   {30'b0, a_gnt, b_gnt}, exp_s ? 32'd1 : 32'd2);
      tick();
      chk("rr_valid", {31'b0, y_valid}, 32'd1);
      chk("rr_src",   {31'b0, y_src},   {31'b0, exp_s});
      chk("rr_data",  y_data,           exp_d);
    end
    hold = exp_d;

    // full buffer, consumer stalled, B waiting
    a_req = 1'b0; b_req = 1'b1; b_data = 32'h1F; y_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_b_gnt", {31'b0, b_gnt}, 32'd0);
      tick();
      chk("stall_valid", {31'b0, y_valid}, 32'd1);
      chk("stall_data",  y_data,           hold);
    end
    y_ready = 1'b1;
    #1;
    chk("release_b_gnt", {31'b0, b_gnt}, 32'd1);
    tick();
    b_req = 1'b0;
    chk("release_data", y_data,         32'h1F);
    chk("release_src",  {31'b0, y_src}, 32'd1);

    // one-cycle B pulse while full: withdrawn, never transferred
    y_ready = 1'b0; b_req = 1'b1; b_data = 32'h1D;
    #1;
    chk("pulse_b_gnt", {31'b0, b_gnt}, 32'd0);
    tick();
    b_req = 1'b0;
    chk("pulse_data", y_data, 32'h1F);
    y_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("pulse_valid", {31'b0, y_valid}, 32'd0);
      chk("pulse_data2", y_data,           32'h1F);
    end

    // one transfer then idle drain
    a_req = 1'b1; a_data = 32'h33;
    tick();
    a_req = 1'b0;
    chk("idle_first_valid", {31'b0, y_valid}, 32'd1);
    chk("idle_first_data",  y_data,           32'h33);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle_valid", {31'b0, y_valid}, 32'd0);
      chk("idle_data",  y_data,           32'h33);
    end

    // reset while holding a word
    b_req = 1'b1; b_data = 32'h44;
    tick();
    chk("pre_rst_valid", {31'b0, y_valid}, 32'd1);
    chk("pre_rst_src",   {31'b0, y_src},   32'd1);
    y_ready = 1'b0; a_req = 1'b1; a_data = 32'h55; b_data = 32'h66;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", {31'b0, y_valid}, 32'd0);
    chk("mid_rst_data",  y_data,           32'd0);
    chk("mid_rst_src",   {31'b0, y_src},   32'd0);
    chk("mid_rst_gnt",   {30'b0, a_gnt, b_gnt}, 32'd0);
    #1 rst = 1'b0;
    y_ready = 1'b1;
    #1;
    chk("post_rst_a_gnt", {31'b0, a_gnt},   32'd1);
    chk("post_rst_sel",   {31'b0, mux_sel}, 32'd0);
    tick();
    a_req = 1'b0; b_req = 1'b0;
    chk("post_rst_data", y_data,         32'h55);
    chk("post_rst_src",  {31'b0, y_src}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
